stopwatch_ctrl: RTL and testbench

Control sequencer for the stopwatch datapath: the BCD time counter and the 7-segment display driver on the PMOD pins. Takes the three raw user buttons and debounces them. Runs the start/pause/lap/clear state machine and generates the count-enable tick that advances the time counter. Drives the display hold/latch controls and the clear strobe; sits between the board pins and the counter/display blocks inside top.

---
 rtl/stopwatch_ctrl.sv | 265 ++++++++++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer.
//  - Three raw buttons are synchronised and debounced. Each debounced
//    rising edge becomes a one-cycle event.
//  - A start/pause/lap/clear state machine drives the time-counter enable
//    (TICK), the clear strobe (CLR_OUT) and the display lap controls
//    (LAP_LATCH, HOLD).
//
// Signalling: there is no valid/ready handshake on this block. TICK,
// CLR_OUT and LAP_LATCH are single-cycle strobes that the consumer acts on
// in the cycle they are high. HOLD, RUNNING and STATE are levels derived
// directly from the state register. STATE doubles as the FSM debug view.
`timescale 1ns/1ps

// Synchroniser and debouncer for one raw button input.
module stopwatch_btn #(
    parameter int DEB_CYCLES = 120000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level_d;
    logic [CW-1:0] stable_cnt;

    // Two-flop synchroniser for the asynchronous raw input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: the level follows the synchronised input only after it has
    // disagreed for DEB_CYCLES consecutive samples. Any agreeing sample
    // restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level      <= 1'b0;
            stable_cnt <= '0;
        end else if (sync2 == level) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CW'(DEB_CYCLES - 1)) begin
            level      <= sync2;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

    // Previous debounced level, used to form a one-cycle press event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    // Press event only. A release produces nothing.
    always_comb begin
        rise = level & ~level_d;
    end

endmodule

// Stopwatch sequencer top.
module stopwatch_ctrl #(
    parameter int TICK_DIV   = 120000,
    parameter int DEB_CYCLES = 120000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_START,
    input  logic       BTN_LAP,
    input  logic       BTN_CLR,
    input  logic       CNT_MAX,
    output logic       TICK,
    output logic       CLR_OUT,
    output logic       LAP_LATCH,
    output logic       HOLD,
    output logic       RUNNING,
    output logic [2:0] STATE
);

    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_LAP   = 3'd3,
        S_SAT   = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] presc;
    logic          lap_latch_q;
    logic          clr_out_q;
    logic          lap_latch_nxt;
    logic          clr_out_nxt;

    logic start_lvl;
    logic lap_lvl;
    logic clr_lvl;
    logic start_rise;
    logic lap_rise;
    logic clr_rise;

    logic ev_start;
    logic ev_lap;
    logic ev_clr;
    logic counting;
    logic tick_c;

    stopwatch_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn_start (
        .clk   (CLK),
        .rst   (RST),
        .raw   (BTN_START),
        .level (start_lvl),
        .rise  (start_rise)
    );

    stopwatch_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn_lap (
        .clk   (CLK),
        .rst   (RST),
        .raw   (BTN_LAP),
        .level (lap_lvl),
        .rise  (lap_rise)
    );

    stopwatch_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn_clr (
        .clk   (CLK),
        .rst   (RST),
        .raw   (BTN_CLR),
        .level (clr_lvl),
        .rise  (clr_rise)
    );

    // Debounced levels are not needed beyond edge detection. They are kept
    // visible so a checker can bind to them.
    logic [2:0] btn_levels;
    always_comb begin
        btn_levels = {clr_lvl, lap_lvl, start_lvl};
    end

    // Event priority clr > start > lap. A higher-priority event swallows
    // any lower-priority one in the same cycle, even when the winner is
    // itself ignored in the current state (e.g. clr while running).
    always_comb begin
        ev_clr   = clr_rise;
        ev_start = start_rise & ~clr_rise;
        ev_lap   = lap_rise & ~clr_rise & ~start_rise;
    end

    // Count enable and tick generation. A tick can only occur while counting.
    always_comb begin
        counting = (state == S_RUN) || (state == S_LAP);
        tick_c   = counting && (presc == PW'(TICK_DIV - 1));
    end

    // Next-state and strobe decode. A saturating tick outranks button events,
    // because the counter has already reached its limit.
    always_comb begin
        state_nxt     = state;
        lap_latch_nxt = 1'b0;
        clr_out_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (ev_start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (tick_c && CNT_MAX) begin
                    state_nxt = S_SAT;
                end else if (ev_start) begin
                    state_nxt = S_PAUSE;
                end else if (ev_lap) begin
                    state_nxt     = S_LAP;
                    lap_latch_nxt = 1'b1;
                end
            end
            S_LAP: begin
                if (tick_c && CNT_MAX) begin
                    state_nxt = S_SAT;
                end else if (ev_start) begin
                    state_nxt = S_PAUSE;
                end else if (ev_lap) begin
                    state_nxt = S_RUN;
                end
            end
            S_PAUSE: begin
                if (ev_clr) begin
                    state_nxt   = S_IDLE;
                    clr_out_nxt = 1'b1;
                end else if (ev_start) begin
                    state_nxt = S_RUN;
                end
            end
            S_SAT: begin
                if (ev_clr) begin
                    state_nxt   = S_IDLE;
                    clr_out_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register with registered one-cycle strobes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            lap_latch_q <= 1'b0;
            clr_out_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            lap_latch_q <= lap_latch_nxt;
            clr_out_q   <= clr_out_nxt;
        end
    end

    // Prescaler. It runs while counting and holds through PAUSE, so a resume
    // keeps the partial tick. It is cleared in IDLE and SAT.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc <= '0;
        end else if (counting) begin
            if (tick_c) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
        end else if (state == S_PAUSE) begin
            presc <= presc;
        end else begin
            presc <= '0;
        end
    end

    // Output mapping. The levels come straight from the state register, so
    // an asynchronous reset clears them without waiting for a clock edge.
    always_comb begin
        TICK      = tick_c;
        CLR_OUT   = clr_out_q;
        LAP_LATCH = lap_latch_q;
        HOLD      = (state == S_LAP);
        RUNNING   = counting;
        STATE     = state;
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed testbench for stopwatch_ctrl with TICK_DIV=4 and DEB_CYCLES=3.
// A button raised just after edge E0 changes STATE on edge E0+6. Timing
// comments below count edges from the RUN entry edge R.
`timescale 1ns/1ps

module tb_stopwatch_ctrl;

  logic       CLK;
  logic       RST;
  logic       BTN_START;
  logic       BTN_LAP;
  logic       BTN_CLR;
  logic       CNT_MAX;
  logic       TICK;
  logic       CLR_OUT;
  logic       LAP_LATCH;
  logic       HOLD;
  logic       RUNNING;
  logic [2:0] STATE;

  int n_checks;
  int n_errors;

  // Observation vector: {STATE, RUNNING, HOLD, TICK, LAP_LATCH, CLR_OUT}.
  wire [7:0] obs = {STATE, RUNNING, HOLD, TICK, LAP_LATCH, CLR_OUT};

  stopwatch_ctrl #(.TICK_DIV(4), .DEB_CYCLES(3)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .BTN_START (BTN_START),
    .BTN_LAP   (BTN_LAP),
    .BTN_CLR   (BTN_CLR),
    .CNT_MAX   (CNT_MAX),
    .TICK      (TICK),
    .CLR_OUT   (CLR_OUT),
    .LAP_LATCH (LAP_LATCH),
    .HOLD      (HOLD),
    .RUNNING   (RUNNING),
    .STATE     (STATE)
  );

  // Clock and reset.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "watchdog");
  end

  // Advance n rising edges and settle 1 ns after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    BTN_START = 1'b0;
    BTN_LAP = 1'b0;
    BTN_CLR = 1'b0;
    CNT_MAX = 1'b0;
    step(3);
    RST = 1'b0;
    step(1);
  endtask

  // Press a button (0=start, 1=lap, 2=clr), return on the edge that acts on it.
  task automatic press_btn(input int which);
    if (which == 0) BTN_START = 1'b1;
    else if (which == 1) BTN_LAP = 1'b1;
    else BTN_CLR = 1'b1;
    step(6);
    BTN_START = 1'b0;
    BTN_LAP = 1'b0;
    BTN_CLR = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    BTN_START = 1'b0;
    BTN_LAP = 1'b0;
    BTN_CLR = 1'b0;
    CNT_MAX = 1'b0;
    step(2);
    n_checks++;
    if (obs !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 8'h00);
    end
    RST = 1'b0;
    step(3);
    n_checks++;
    if (obs !== 8'h00) begin
      n_errors++;
      $display("FAIL idle_after_reset: got %h expected %h", obs, 8'h00);
    end
  endtask

  task automatic test_start();
    do_reset();
    BTN_START = 1'b1;
    step(5);
    n_checks++;
    if (STATE !== 3'd0) begin
      n_errors++;
      $display("FAIL start_latency_early: state %0d expected 0", STATE);
    end
    step(1);
    n_checks++;
    if (obs !== {3'd1, 5'b10000}) begin
      n_errors++;
      $display("FAIL start_latency: got %h expected %h", obs, {3'd1, 5'b10000});
    end
    // Held for 20 edges in total; tick on R+3, R+7, R+11.
    for (int k = 1; k <= 14; k++) begin
      step(1);
      if (k == 14) BTN_START = 1'b0;
      n_checks++;
      if (obs !== {3'd1, 2'b10, ((k % 4) == 3), 2'b00}) begin
        n_errors++;
        $display("FAIL run_tick k=%0d: got %h expected %h", k, obs,
                 {3'd1, 2'b10, ((k % 4) == 3), 2'b00});
      end
    end
  endtask

  task automatic test_pause_resume();
    int ticks;
    do_reset();
    press_btn(0);            // RUN at R, prescaler 0
    step(4);                 // R+4
    press_btn(0);            // PAUSE at R+10, prescaler 2
    n_checks++;
    if (STATE !== 3'd2 || RUNNING !== 1'b0) begin
      n_errors++;
      $display("FAIL pause_enter: state %0d running %0b expected 2 0", STATE, RUNNING);
    end
    ticks = 0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (TICK === 1'b1) ticks++;
    end
    n_checks++;
    if (ticks !== 0) begin
      n_errors++;
      $display("FAIL pause_no_tick: got %0d ticks expected 0", ticks);
    end
    press_btn(0);            // back to RUN, prescaler still 2
    n_checks++;
    if (obs !== {3'd1, 5'b10000}) begin
      n_errors++;
      $display("FAIL resume_state: got %h expected %h", obs, {3'd1, 5'b10000});
    end
    step(1);
    n_checks++;
    if (TICK !== 1'b1) begin
      n_errors++;
      $display("FAIL resume_first_tick: got %0b expected 1", TICK);
    end
    step(1);
    n_checks++;
    if (TICK !== 1'b0) begin
      n_errors++;
      $display("FAIL resume_tick_width: got %0b expected 0", TICK);
    end
  endtask

  task automatic test_lap();
    int latches;
    do_reset();
    press_btn(0);            // RUN at R
    step(4);
    press_btn(1);            // LAP at R+10
    n_checks++;
    if (obs !== {3'd3, 5'b11010}) begin
      n_errors++;
      $display("FAIL lap_enter: got %h expected %h", obs, {3'd3, 5'b11010});
    end
    latches = 0;
    for (int k = 11; k <= 22; k++) begin
      step(1);
      if (k == 16) BTN_LAP = 1'b1;
      if (LAP_LATCH === 1'b1) latches++;
      n_checks++;
      if (obs !== {((k < 22) ? 3'd3 : 3'd1), 1'b1, (k < 22), ((k % 4) == 3), 2'b00}) begin
        n_errors++;
        $display("FAIL lap_hold k=%0d: got %h expected %h", k, obs,
                 {((k < 22) ? 3'd3 : 3'd1), 1'b1, (k < 22), ((k % 4) == 3), 2'b00});
      end
      if (k == 22) BTN_LAP = 1'b0;
    end
    n_checks++;
    if (latches !== 0) begin
      n_errors++;
      $display("FAIL lap_latch_single: got %0d extra pulses expected 0", latches);
    end
  endtask

  task automatic test_clear_gating();
    int clrs;
    do_reset();
    press_btn(0);            // RUN at R
    step(4);
    BTN_CLR = 1'b1;
    clrs = 0;
    for (int k = 5; k <= 12; k++) begin
      step(1);
      if (k == 10) BTN_CLR = 1'b0;
      if (CLR_OUT === 1'b1) clrs++;
      n_checks++;
      if (STATE !== 3'd1) begin
        n_errors++;
        $display("FAIL clr_in_run k=%0d: state %0d expected 1", k, STATE);
      end
    end
    n_checks++;
    if (clrs !== 0) begin
      n_errors++;
      $display("FAIL clr_in_run_strobe: got %0d pulses expected 0", clrs);
    end
    step(2);
    press_btn(0);            // PAUSE
    n_checks++;
    if (STATE !== 3'd2) begin
      n_errors++;
      $display("FAIL clr_pause_enter: state %0d expected 2", STATE);
    end
    step(4);
    press_btn(2);            // IDLE with clear strobe
    n_checks++;
    if (obs !== {3'd0, 5'b00001}) begin
      n_errors++;
      $display("FAIL clr_in_pause: got %h expected %h", obs, {3'd0, 5'b00001});
    end
    step(1);
    n_checks++;
    if (obs !== 8'h00) begin
      n_errors++;
      $display("FAIL clr_strobe_width: got %h expected %h", obs, 8'h00);
    end
  endtask

  task automatic test_bounce();
    int moved;
    do_reset();
    moved = 0;
    for (int i = 0; i < 30; i++) begin
      BTN_START = (((i / 2) % 2) == 0);
      step(1);
      if (STATE !== 3'd0) moved++;
    end
    BTN_START = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (STATE !== 3'd0) moved++;
    end
    n_checks++;
    if (moved !== 0) begin
      n_errors++;
      $display("FAIL bounce_ignored: got %0d non-idle cycles expected 0", moved);
    end
  endtask

  task automatic test_simultaneous();
    int run_seen;
    do_reset();
    press_btn(0);            // RUN
    step(4);
    press_btn(0);            // PAUSE
    step(4);
    BTN_START = 1'b1;
    BTN_CLR = 1'b1;
    run_seen = 0;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      if (STATE === 3'd1) run_seen++;
    end
    BTN_START = 1'b0;
    BTN_CLR = 1'b0;
    n_checks++;
    if (obs !== {3'd0, 5'b00001}) begin
      n_errors++;
      $display("FAIL simul_clr_wins: got %h expected %h", obs, {3'd0, 5'b00001});
    end
    for (int k = 0; k < 8; k++) begin
      step(1);
      if (STATE === 3'd1) run_seen++;
    end
    n_checks++;
    if (run_seen !== 0) begin
      n_errors++;
      $display("FAIL simul_no_run: got %0d run cycles expected 0", run_seen);
    end
  endtask

  task automatic test_saturation();
    int bad;
    do_reset();
    press_btn(0);            // RUN at R, prescaler 0
    CNT_MAX = 1'b1;
    step(3);
    n_checks++;
    if (obs !== {3'd1, 5'b10100}) begin
      n_errors++;
      $display("FAIL sat_last_tick: got %h expected %h", obs, {3'd1, 5'b10100});
    end
    step(1);
    n_checks++;
    if (obs !== {3'd4, 5'b00000}) begin
      n_errors++;
      $display("FAIL sat_enter: got %h expected %h", obs, {3'd4, 5'b00000});
    end
    step(2);
    BTN_START = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (k == 6) BTN_START = 1'b0;
      if (STATE !== 3'd4 || TICK !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_errors++;
      $display("FAIL sat_ignores_start: got %0d bad cycles expected 0", bad);
    end
    step(2);
    press_btn(2);
    n_checks++;
    if (obs !== {3'd0, 5'b00001}) begin
      n_errors++;
      $display("FAIL sat_clear: got %h expected %h", obs, {3'd0, 5'b00001});
    end
    CNT_MAX = 1'b0;
  endtask

  task automatic test_async_reset();
    int bad;
    do_reset();
    press_btn(0);
    step(4);
    press_btn(1);            // LAP
    n_checks++;
    if (HOLD !== 1'b1 || STATE !== 3'd3) begin
      n_errors++;
      $display("FAIL areset_lap_setup: hold %0b state %0d expected 1 3", HOLD, STATE);
    end
    #2;
    RST = 1'b1;
    #1;
    n_checks++;
    if (obs !== 8'h00) begin
      n_errors++;
      $display("FAIL areset_immediate: got %h expected %h", obs, 8'h00);
    end
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      step(1);
      if (obs !== 8'h00) bad++;
    end
    RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1);
      if (obs !== 8'h00) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_errors++;
      $display("FAIL areset_quiet: got %0d bad cycles expected 0", bad);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_start();
    test_pause_resume();
    test_lap();
    test_clear_gating();
    test_bounce();
    test_simultaneous();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
